// File: rtl/sprite_pkg.sv
// ============================================================================
// sprite_pkg: screen geometry, colour type and FSM state encoding shared by
// the sprite drawer. Revision: 1.0
// ============================================================================
`default_nettype none

package sprite_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/box_scanner.sv
// ============================================================================
// box_scanner: row-major dx/dy walker over a BOX_W x BOX_H box; wraps to the
// origin after the last pixel so ERASE can hand straight over to DRAW.
// Revision: 1.0
// ============================================================================
`default_nettype none

module box_scanner
  import sprite_pkg::*;
#(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       advance,
  output logic [3:0] dx,
  output logic [3:0] dy,
  output logic       last
);

  localparam logic [3:0] DX_MAX = 4'(BOX_W - 1);
  localparam logic [3:0] DY_MAX = 4'(BOX_H - 1);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      dx <= '0;
      dy <= '0;
    end else if (advance) begin
      if (dx == DX_MAX) begin
        dx <= '0;
        dy <= (dy == DY_MAX) ? 4'd0 : dy + 4'd1;
      end else begin
        dx <= dx + 4'd1;
      end
    end
  end

  assign last = (dx == DX_MAX) && (dy == DY_MAX);

endmodule

`default_nettype wire

// File: rtl/sprite_drawer.sv
// ============================================================================
// sprite_drawer: moves a solid BOX_W x BOX_H sprite on a 160x120 VGA frame,
// optionally erasing the previous box first (macro SPRITE_ERASE_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_drawer
  import sprite_pkg::*;
#(
  parameter int      BOX_W     = 4,
  parameter int      BOX_H     = 4,
  parameter colour_t BG_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  state_t     state;
  state_t     state_nxt;

  logic [7:0] new_x;
  logic [6:0] new_y;
  colour_t    new_colour;

  logic [3:0] dx;
  logic [3:0] dy;
  logic       scan_start;
  logic       scan_advance;
  logic       scan_last;

  logic [8:0] pix_x;
  logic [7:0] pix_y;
  colour_t    pix_colour;
  logic       pix_on;
  logic       pix_vis;

`ifdef SPRITE_ERASE_EN
  logic [7:0] old_x;
  logic [6:0] old_y;
  logic       old_valid;
`endif

  box_scanner #(
    .BOX_W (BOX_W),
    .BOX_H (BOX_H)
  ) u_scanner (
    .clk     (CLOCK_50),
    .reset   (reset),
    .start   (scan_start),
    .advance (scan_advance),
    .dx      (dx),
    .dy      (dy),
    .last    (scan_last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef SPRITE_ERASE_EN
          state_nxt = old_valid ? ERASE : DRAW;
`else
          state_nxt = DRAW;
`endif
        end
      end
      ERASE:   if (scan_last) state_nxt = DRAW;
      DRAW:    if (scan_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel coordinates carry one extra bit so off-screen pixels can be clipped.
  always_comb begin
    scan_start   = (state == IDLE);
    scan_advance = (state == ERASE) || (state == DRAW);
    busy         = scan_advance;
    pix_on       = 1'b0;
    pix_x        = {1'b0, new_x} + 9'(dx);
    pix_y        = {1'b0, new_y} + 8'(dy);
    pix_colour   = new_colour;
    case (state)
`ifdef SPRITE_ERASE_EN
      ERASE: begin
        pix_on     = 1'b1;
        pix_x      = {1'b0, old_x} + 9'(dx);
        pix_y      = {1'b0, old_y} + 8'(dy);
        pix_colour = BG_COLOUR;
      end
`endif
      DRAW:    pix_on = 1'b1;
      default: pix_on = 1'b0;
    endcase
    pix_vis = pix_on && (pix_x < 9'(SCREEN_W)) && (pix_y < 8'(SCREEN_H));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      new_x      <= '0;
      new_y      <= '0;
      new_colour <= '0;
    end else if ((state == IDLE) && start) begin
      new_x      <= x_in;
      new_y      <= y_in;
      new_colour <= colour_in;
    end
  end

`ifdef SPRITE_ERASE_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      old_x     <= '0;
      old_y     <= '0;
      old_valid <= 1'b0;
    end else if (state == DONE) begin
      old_x     <= new_x;
      old_y     <= new_y;
      old_valid <= 1'b1;
    end
  end
`endif

  // Registered VGA-side outputs; the pen colour drops back to background after a move.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= pix_vis;
      done <= (state == DONE);
      if (pix_on) begin
        x_out      <= pix_x[7:0];
        y_out      <= pix_y[6:0];
        colour_out <= pix_colour;
      end else if (state == DONE) begin
        colour_out <= BG_COLOUR;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_drawer.sv
// ============================================================================
// tb_sprite_drawer: directed and random sprite moves checked against a
// pixel-list reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sprite_drawer;

  localparam int W = 4;
  localparam int H = 4;
`ifdef SPRITE_ERASE_EN
  localparam bit ERASE_ON = 1'b1;
`else
  localparam bit ERASE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  sprite_drawer #(
    .BOX_W     (W),
    .BOX_H     (H),
    .BG_COLOUR (3'b000)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
    bit vis;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   model_valid = 1'b0;
  int   model_x = 0;
  int   model_y = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic add_box(input int bx, input int by, input int c);
    for (int dy = 0; dy < H; dy++) begin
      for (int dx = 0; dx < W; dx++) begin
        pix_t p;
        p.x   = bx + dx;
        p.y   = by + dy;
        p.c   = c;
        p.vis = (p.x < 160) && (p.y < 120);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic build_expect(input int x, input int y, input int c);
    exp_q.delete();
    if (ERASE_ON && model_valid) add_box(model_x, model_y, 0);
    add_box(x, y, c);
  endtask

  task automatic issue_start(input int x, input int y, input int c);
    @(negedge clk);
    start     = 1'b1;
    x_in      = 8'(x);
    y_in      = 7'(y);
    colour_in = 3'(c);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    check("plot_after_accept", 32'(plot), 0);
  endtask

  task automatic check_pixel(input int i);
    check("plot", 32'(plot), 32'(exp_q[i].vis));
    check("done_mid", 32'(done), 0);
    check("busy_mid", 32'(busy), 32'(i < exp_q.size() - 1));
    if (exp_q[i].vis) begin
      check("x_out", 32'(x_out), exp_q[i].x);
      check("y_out", 32'(y_out), exp_q[i].y);
      check("colour_out", 32'(colour_out), exp_q[i].c);
    end
  endtask

  // poke_at >= 0 pulses a stray start just before that pixel's edge.
  task automatic run_move(input int x, input int y, input int c, input int poke_at);
    build_expect(x, y, c);
    issue_start(x, y, c);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == poke_at) begin
        start     = 1'b1;
        x_in      = 8'($urandom_range(0, 159));
        y_in      = 7'($urandom_range(0, 119));
        colour_in = 3'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      check_pixel(i);
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 1);
    check("plot_on_done", 32'(plot), 0);
    check("busy_on_done", 32'(busy), 0);
    @(negedge clk);
    check("done_single", 32'(done), 0);
    check("plot_after_done", 32'(plot), 0);
    model_valid = 1'b1;
    model_x     = x;
    model_y     = y;
  endtask

  // Reset lands on the fifth scan cycle of the move.
  task automatic run_reset_abort(input int x, input int y, input int c);
    build_expect(x, y, c);
    issue_start(x, y, c);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_pixel(i);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("plot_after_abort", 32'(plot), 0);
    check("busy_after_abort", 32'(busy), 0);
    check("done_after_abort", 32'(done), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("quiet_plot", 32'(plot), 0);
      check("quiet_done", 32'(done), 0);
    end
    model_valid = 1'b0;
  endtask

  initial begin
    int rx;
    int ry;
    int poke;

    repeat (3) @(negedge clk);
    check("rst_x_out", 32'(x_out), 0);
    check("rst_y_out", 32'(y_out), 0);
    check("rst_colour_out", 32'(colour_out), 0);
    check("rst_plot", 32'(plot), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_move(10, 20, 3'b100, -1);
    run_move(11, 20, 3'b100, -1);
    run_move(158, 118, 3'b010, -1);
    run_move(50, 60, 3'b001, 10);
    run_reset_abort(70, 30, 3'b101);
    run_move(80, 90, 3'b110, -1);

    for (int n = 0; n < 8; n++) begin
      if (n % 3 == 0) begin
        rx = $urandom_range(154, 159);
        ry = $urandom_range(114, 119);
      end else begin
        rx = $urandom_range(0, 159);
        ry = $urandom_range(0, 119);
      end
      poke = (n % 2 == 0) ? int'($urandom_range(0, 14)) : -1;
      run_move(rx, ry, int'($urandom_range(0, 7)), poke);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_drawer.md
SPRITE_DRAWER -- requirements
Module: sprite_drawer

Interface
REQ-001 Parameter BOX_W, default 4, sprite width in pixels (1..16).
REQ-002 Parameter BOX_H, default 4, sprite height in pixels (1..16).
REQ-003 Parameter BG_COLOUR, default 3'b000, colour used to erase.
REQ-004 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to move the sprite to x_in/y_in.
REQ-007 x_in  in  8  new sprite left column, 0..159.
REQ-008 y_in  in  7  new sprite top row, 0..119.
REQ-009 colour_in  in  3  sprite colour, RGB 1 bit each.
REQ-010 x_out  out  8  pixel column to the VGA adapter.
REQ-011 y_out  out  7  pixel row to the VGA adapter.
REQ-012 colour_out  out  3  pixel colour to the VGA adapter.
REQ-013 plot  out  1  write enable to the VGA adapter, one pixel per high cycle.
REQ-014 busy  out  1  high while ERASE or DRAW is active.
REQ-015 done  out  1  one-cycle pulse when a move completes.

Function
REQ-016 FSM states SHALL be IDLE, ERASE, DRAW, DONE.
REQ-017 IDLE: start=1 SHALL latch x_in, y_in and colour_in, then go to ERASE if an old position is valid, else DRAW.
REQ-018 start SHALL be ignored in every state other than IDLE; no queuing.
REQ-019 ERASE SHALL last exactly BOX_W*BOX_H cycles, emitting the old box pixels with colour_out=BG_COLOUR.
REQ-020 DRAW SHALL last exactly BOX_W*BOX_H cycles, emitting the new box pixels with the latched colour.
REQ-021 Scan order SHALL be row-major: dx 0..BOX_W-1 inner, dy 0..BOX_H-1 outer, starting at (base_x, base_y).
REQ-022 The first pixel SHALL appear on the cycle after start is accepted, with no gap between ERASE and DRAW.
REQ-023 After the last DRAW pixel the FSM SHALL enter DONE for one cycle (done=1, plot=0), then return to IDLE.
REQ-024 On DONE the latched new position SHALL become the old position, and the old-valid flag SHALL be set.
REQ-025 Pixel coordinates SHALL be computed at 9/8 bits; any pixel with x>=160 or y>=120 SHALL have plot=0 but still consume its cycle (clipping).
REQ-026 x_out, y_out and colour_out SHALL be registered; plot SHALL be aligned to them in the same cycle.
REQ-027 busy SHALL be 1 exactly in ERASE and DRAW.

Reset
REQ-028 reset SHALL force IDLE, clear the old-valid flag, and clear the pixel counters.
REQ-029 After reset, x_out=0, y_out=0, colour_out=0, plot=0, busy=0 and done=0.
REQ-030 reset asserted mid-ERASE or mid-DRAW SHALL abort on the next edge with no further plot and no done pulse.

Configuration
REQ-031 Macro SPRITE_ERASE_EN defined: ERASE behaves as specified above.
REQ-032 SPRITE_ERASE_EN undefined: ERASE is not compiled in; every accepted start goes directly to DRAW and old sprites are left on screen.

Structure
REQ-033 Shared package sprite_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, the 3-bit colour typedef and the state enum.
REQ-034 One sub-module, box_scanner, SHALL generate dx/dy, with start, advance and last outputs; it is reused by ERASE and DRAW.

Verification
REQ-035 Reset, then start with (10,20), colour 3'b100 -> no erase; 16 plot cycles covering x 10..13, y 20..23 in red; done on cycle 18.
REQ-036 Second start with (11,20), colour 3'b100 -> 16 erase pixels at the old box in 3'b000, then 16 draw pixels at the new box; done 34 cycles after start.
REQ-037 start with (158,118) -> only the 4 pixels with x<=159 and y<=119 plotted; still 16 DRAW cycles.
REQ-038 start pulsed again during DRAW -> ignored; position unchanged; exactly one done pulse.
REQ-039 reset asserted on the 5th ERASE cycle -> plot=0 and busy=0 next cycle; the next start draws without an erase.
REQ-040 Build without SPRITE_ERASE_EN, issue two starts -> no BG_COLOUR pixels; each move takes 16 plot cycles.
